// File: rtl/dmem_apb_arbiter.sv
// Round-robin two-port arbiter sequencing data memory accesses over APB.
// Port 0 is the LSU, port 1 the debug/DMA agent.
module dmem_apb_arbiter #(
    parameter int DMEM_W = 12
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [1:0]             m_req_i,
    input  logic [1:0]             m_we_i,
    input  logic [1:0][DMEM_W-1:0] m_addr_i,
    input  logic [1:0][31:0]       m_wdata_i,
    input  logic [1:0][3:0]        m_be_i,
    output logic [1:0]             m_gnt_o,
    output logic [1:0]             m_rvalid_o,
    output logic [31:0]            m_rdata_o,
    output logic [DMEM_W-1:0]      paddr_o,
    output logic                   psel_o,
    output logic                   penable_o,
    output logic                   pwrite_o,
    output logic [31:0]            pwdata_o,
    output logic [3:0]             pstrb_o,
    input  logic [31:0]            prdata_i,
    input  logic                   pready_i
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       last_q;
    logic       owner_q;
    logic       winner;
    logic       grant;
    logic       done;

    // On a tie the port not served last wins; otherwise the lone requester.
    assign winner = (m_req_i == 2'b11) ? ~last_q : m_req_i[1];
    assign grant  = (state_q == IDLE) && (|m_req_i) && !rst_i;
    assign done   = (state_q == ACCESS) && pready_i;

    assign m_gnt_o   = grant ? (winner ? 2'b10 : 2'b01) : 2'b00;
    assign psel_o    = (state_q != IDLE);
    assign penable_o = (state_q == ACCESS);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (pready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            owner_q    <= 1'b0;
            paddr_o    <= '0;
            pwrite_o   <= 1'b0;
            pwdata_o   <= '0;
            pstrb_o    <= '0;
            m_rdata_o  <= '0;
            m_rvalid_o <= '0;
        end else begin
            state_q    <= state_d;
            m_rvalid_o <= '0;
            if (grant) begin
                last_q   <= winner;
                owner_q  <= winner;
                paddr_o  <= m_addr_i[winner];
                pwrite_o <= m_we_i[winner];
                pwdata_o <= m_wdata_i[winner];
                pstrb_o  <= m_we_i[winner] ? m_be_i[winner] : 4'b0000;
            end
            if (done) begin
                m_rvalid_o <= owner_q ? 2'b10 : 2'b01;
                if (!pwrite_o) m_rdata_o <= prdata_i;
            end
        end
    end

endmodule

// File: tb/tb_dmem_apb_arbiter.sv
// Bench for dmem_apb_arbiter: directed table, corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_dmem_apb_arbiter;

    localparam int W = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [1:0]          req;
    logic [1:0]          we;
    logic [1:0][W-1:0]   addr;
    logic [1:0][31:0]    wdata;
    logic [1:0][3:0]     be;
    logic [31:0]         prdata;
    logic                pready;
    logic [1:0]          m_gnt_o;
    logic [1:0]          m_rvalid_o;
    logic [31:0]         m_rdata_o;
    logic [W-1:0]        paddr_o;
    logic                psel_o;
    logic                penable_o;
    logic                pwrite_o;
    logic [31:0]         pwdata_o;
    logic [3:0]          pstrb_o;

    dmem_apb_arbiter #(.DMEM_W(W)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .m_req_i    (req),
        .m_we_i     (we),
        .m_addr_i   (addr),
        .m_wdata_i  (wdata),
        .m_be_i     (be),
        .m_gnt_o    (m_gnt_o),
        .m_rvalid_o (m_rvalid_o),
        .m_rdata_o  (m_rdata_o),
        .paddr_o    (paddr_o),
        .psel_o     (psel_o),
        .penable_o  (penable_o),
        .pwrite_o   (pwrite_o),
        .pwdata_o   (pwdata_o),
        .pstrb_o    (pstrb_o),
        .prdata_i   (prdata),
        .pready_i   (pready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: one outstanding transfer with an age counter
    // (cycles since grant); ACCESS phase is age >= 2.
    bit          mb;
    int          mage;
    int          mown;
    int          mlast;
    logic [W-1:0] mpaddr;
    logic        mpw;
    logic [31:0] mpwd;
    logic [3:0]  mpst;
    logic [31:0] mrd;
    logic [1:0]  mrv;

    function automatic logic [1:0] exp_gnt();
        if (rst || mb || req == 2'b00) return 2'b00;
        if (req == 2'b11) return (mlast == 1) ? 2'b01 : 2'b10;
        return req;
    endfunction

    task automatic model_step();
        logic [1:0] g;
        int w;
        g = exp_gnt();
        if (rst) begin
            mb = 0; mage = 0; mown = 0; mlast = 1;
            mpaddr = '0; mpw = 0; mpwd = '0; mpst = '0;
            mrd = '0; mrv = '0;
        end else begin
            mrv = '0;
            if (mb) begin
                if (mage >= 2 && pready) begin
                    mrv[mown] = 1'b1;
                    if (!mpw) mrd = prdata;
                    mb = 0;
                end else begin
                    mage++;
                end
            end else if (g != 2'b00) begin
                w = g[1] ? 1 : 0;
                mb = 1; mage = 1; mown = w; mlast = w;
                mpaddr = addr[w];
                mpw = we[w];
                mpwd = wdata[w];
                mpst = we[w] ? be[w] : 4'b0000;
            end
        end
    endtask

    task automatic check_model(input string name);
        chk(name,
            {m_gnt_o, m_rvalid_o, psel_o, penable_o, pwrite_o,
             paddr_o, pwdata_o, pstrb_o, m_rdata_o},
            {exp_gnt(), mrv, mb, (mb && mage >= 2), mpw,
             mpaddr, mpwd, mpst, mrd});
    endtask

    task automatic adv();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        req = 2'b00;
        repeat (n) begin
            @(negedge clk);
            adv();
        end
        rst = 1'b0;
    endtask

    typedef struct {
        logic [1:0]   req;
        logic [1:0]   we;
        logic [W-1:0] a0;
        logic [W-1:0] a1;
        logic [31:0]  w0;
        logic [31:0]  w1;
        logic [3:0]   b0;
        logic [3:0]   b1;
        logic         prdy;
        logic [31:0]  prd;
        logic [1:0]   gnt;
        logic [1:0]   rv;
        logic         ps;
        logic         pe;
        logic         pw;
        logic [W-1:0] pa;
        logic [31:0]  pwd;
        logic [3:0]   pst;
        logic [31:0]  rd;
    } vec_t;

    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] BY = 32'h00AB0000;

    vec_t tbl[12];

    logic [1:0] g;
    int gcyc[$];
    int gport[$];
    int rport[$];

    initial begin
        tbl[0]  = '{2'b01, 2'b01, 12'h010, 12'h010, DB, 32'h0, 4'hF, 4'h0, 1'b1, DB,
                    2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 4'h0, 32'h0};
        tbl[1]  = '{2'b00, 2'b01, 12'h010, 12'h010, DB, 32'h0, 4'hF, 4'h0, 1'b1, DB,
                    2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 12'h010, DB, 4'hF, 32'h0};
        tbl[2]  = '{2'b00, 2'b01, 12'h010, 12'h010, DB, 32'h0, 4'hF, 4'h0, 1'b1, DB,
                    2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 12'h010, DB, 4'hF, 32'h0};
        tbl[3]  = '{2'b00, 2'b01, 12'h010, 12'h010, DB, 32'h0, 4'hF, 4'h0, 1'b1, DB,
                    2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 12'h010, DB, 4'hF, 32'h0};
        tbl[4]  = '{2'b10, 2'b00, 12'h010, 12'h010, DB, 32'h0, 4'hF, 4'h0, 1'b1, DB,
                    2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 12'h010, DB, 4'hF, 32'h0};
        tbl[5]  = '{2'b00, 2'b00, 12'h010, 12'h010, DB, 32'h0, 4'hF, 4'h0, 1'b1, DB,
                    2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 12'h010, 32'h0, 4'h0, 32'h0};
        tbl[6]  = '{2'b00, 2'b00, 12'h010, 12'h010, DB, 32'h0, 4'hF, 4'h0, 1'b1, DB,
                    2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 12'h010, 32'h0, 4'h0, 32'h0};
        tbl[7]  = '{2'b00, 2'b00, 12'h010, 12'h010, DB, 32'h0, 4'hF, 4'h0, 1'b1, DB,
                    2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 12'h010, 32'h0, 4'h0, DB};
        tbl[8]  = '{2'b01, 2'b01, 12'h020, 12'h010, BY, 32'h0, 4'h4, 4'h0, 1'b1, DB,
                    2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 12'h010, 32'h0, 4'h0, DB};
        tbl[9]  = '{2'b00, 2'b01, 12'h020, 12'h010, BY, 32'h0, 4'h4, 4'h0, 1'b1, DB,
                    2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 12'h020, BY, 4'h4, DB};
        tbl[10] = '{2'b00, 2'b01, 12'h020, 12'h010, BY, 32'h0, 4'h4, 4'h0, 1'b1, DB,
                    2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 12'h020, BY, 4'h4, DB};
        tbl[11] = '{2'b00, 2'b01, 12'h020, 12'h010, BY, 32'h0, 4'h4, 4'h0, 1'b1, DB,
                    2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 12'h020, BY, 4'h4, DB};

        rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; be = '0;
        prdata = '0; pready = 1'b1;
        do_reset(2);

        @(negedge clk);
        chk("reset_state",
            {m_gnt_o, m_rvalid_o, psel_o, penable_o, pwrite_o,
             paddr_o, pwdata_o, pstrb_o, m_rdata_o}, '0);
        adv();

        // Directed table: port 0 write, port 1 read, byte write
        for (int i = 0; i < 12; i++) begin
            req = tbl[i].req; we = tbl[i].we;
            addr[0] = tbl[i].a0; addr[1] = tbl[i].a1;
            wdata[0] = tbl[i].w0; wdata[1] = tbl[i].w1;
            be[0] = tbl[i].b0; be[1] = tbl[i].b1;
            pready = tbl[i].prdy; prdata = tbl[i].prd;
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                {m_gnt_o, m_rvalid_o, psel_o, penable_o, pwrite_o,
                 paddr_o, pwdata_o, pstrb_o, m_rdata_o},
                {tbl[i].gnt, tbl[i].rv, tbl[i].ps, tbl[i].pe, tbl[i].pw,
                 tbl[i].pa, tbl[i].pwd, tbl[i].pst, tbl[i].rd});
            adv();
        end

        // Continuous contention: grants alternate starting with port 0
        do_reset(2);
        req = 2'b11; we = 2'b00;
        addr[0] = 12'h100; addr[1] = 12'h200;
        pready = 1'b1; prdata = 32'h1111_2222;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check_model("rr");
            if (m_gnt_o != 2'b00) begin
                gcyc.push_back(c);
                gport.push_back(int'(m_gnt_o[1]));
            end
            if (m_rvalid_o != 2'b00) rport.push_back(int'(m_rvalid_o[1]));
            adv();
        end
        chk("rr_gnt_count", gcyc.size(), 4);
        for (int i = 0; i < gcyc.size() && i < 4; i++) begin
            chk("rr_gnt_port", gport[i], i % 2);
            chk("rr_gnt_cycle", gcyc[i], 3 * i);
        end
        chk("rr_rv_count", rport.size(), 3);
        for (int i = 0; i < rport.size() && i < 3; i++)
            chk("rr_rv_owner", rport[i], i % 2);

        // Read with two wait states, port 0 waiting behind it
        req = 2'b10; we = 2'b00; addr[1] = 12'h044;
        prdata = 32'hCAFE_F00D;
        for (int k = 0; k < 6; k++) begin
            pready = (k >= 4);
            if (k >= 1) begin
                req = 2'b01; we = 2'b01; addr[0] = 12'h0CC;
                wdata[0] = 32'h1234_5678; be[0] = 4'h3;
            end
            @(negedge clk);
            check_model("wait");
            if (k >= 1 && k <= 4) begin
                chk("wait_nogrant", m_gnt_o, 2'b00);
                chk("wait_norvalid", m_rvalid_o, 2'b00);
            end
            if (k == 5) begin
                chk("wait_rvalid", m_rvalid_o, 2'b10);
                chk("wait_rdata", m_rdata_o, 32'hCAFE_F00D);
                chk("wait_regrant", m_gnt_o, 2'b01);
            end
            adv();
        end

        // Reset during a stalled ACCESS, then a tie goes to port 0
        do_reset(1);
        req = 2'b01; we = 2'b01; addr[0] = 12'h0AA; pready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            rst = (k == 2);
            if (k == 1) req = 2'b00;
            if (k == 3) begin
                req = 2'b11; we = 2'b00;
            end
            if (k == 4) req = 2'b00;
            if (k >= 4) pready = 1'b1;
            @(negedge clk);
            check_model("rst_mid");
            if (k == 3) begin
                chk("rst_psel", psel_o, 1'b0);
                chk("rst_norvalid", m_rvalid_o, 2'b00);
                chk("rst_tie_gnt", m_gnt_o, 2'b01);
            end
            adv();
        end
        rst = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            check_model("rand");
            g = m_gnt_o;
            adv();
            rst = ($urandom_range(0, 299) == 0);
            for (int p = 0; p < 2; p++) begin
                if ((req[p] && g[p] && $urandom_range(0, 1) == 1) ||
                    (!req[p] && $urandom_range(0, 2) == 0)) begin
                    req[p]   = 1'b1;
                    we[p]    = 1'($urandom_range(0, 1));
                    addr[p]  = W'($urandom_range(0, 4095));
                    wdata[p] = $urandom;
                    be[p]    = 4'($urandom_range(0, 15));
                end else if (req[p] && g[p]) begin
                    req[p] = 1'b0;
                end
            end
            pready = ($urandom_range(0, 3) != 0);
            prdata = $urandom;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
